egr_prc_fetch_rsp: RTL and testbench

//  PRC-side responder for the PFS->PRC packet fetch request interface in the EGR partition.

---
 rtl/egr_prc_fetch_rsp.sv | 228 ++++++++++++++++++++++
 tb/tb_egr_prc_fetch_rsp.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egr_prc_fetch_rsp.sv
// PRC-side fetch responder: queues PFS segment-fetch requests, issues one memory read per
// segment and returns tagged SOP/EOP beats under credit flow control. Optional perf counters: EGR_PRC_FETCH_PERF_EN.
module egr_prc_fetch_rsp #(
  parameter int TAG_W     = 8,
  parameter int PTR_W     = 16,
  parameter int LEN_W     = 5,
  parameter int DATA_W    = 64,
  parameter int RD_LAT    = 2,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [PTR_W-1:0]  req_ptr,
  input  logic [LEN_W-1:0]  req_nseg_m1,
  output logic              mem_rd_en,
  output logic [PTR_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_sop,
  output logic              rsp_eop,
  output logic [DATA_W-1:0] rsp_data,
  output logic              idle
`ifdef EGR_PRC_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_req_cnt,
  output logic [31:0]       perf_seg_cnt
`endif
);

  localparam int REQ_AW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int RSP_AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int REQ_CW = $clog2(REQ_DEPTH + 1);
  localparam int RSP_CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  function automatic logic [REQ_AW-1:0] req_inc(input logic [REQ_AW-1:0] p);
    return (p == REQ_AW'(REQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RSP_AW-1:0] rsp_inc(input logic [RSP_AW-1:0] p);
    return (p == RSP_AW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request FIFO
  logic [TAG_W-1:0]  rq_tag_mem [REQ_DEPTH];
  logic [PTR_W-1:0]  rq_ptr_mem [REQ_DEPTH];
  logic [LEN_W-1:0]  rq_len_mem [REQ_DEPTH];
  logic [REQ_AW-1:0] rq_wr, rq_rd;
  logic [REQ_CW-1:0] rq_cnt;
  logic              rq_full, rq_empty, rq_push, rq_pop;

  assign rq_full   = (rq_cnt == REQ_CW'(REQ_DEPTH));
  assign rq_empty  = (rq_cnt == '0);
  assign req_ready = rst_n & ~rq_full;
  assign rq_push   = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_tag_mem[rq_wr] <= req_tag;
      rq_ptr_mem[rq_wr] <= req_ptr;
      rq_len_mem[rq_wr] <= req_nseg_m1;
    end
    if (!rst_n) begin
      rq_wr  <= '0;
      rq_rd  <= '0;
      rq_cnt <= '0;
    end else begin
      if (rq_push) rq_wr <= req_inc(rq_wr);
      if (rq_pop)  rq_rd <= req_inc(rq_rd);
      rq_cnt <= rq_cnt + REQ_CW'(rq_push) - REQ_CW'(rq_pop);
    end
  end

  // Issue FSM: IDLE issues segment 0 straight from the FIFO head so back-to-back requests have no bubble
  state_t            state;
  logic [TAG_W-1:0]  cur_tag;
  logic [PTR_W-1:0]  cur_ptr;
  logic [LEN_W-1:0]  cur_len, idx;
  logic [RSP_CW-1:0] inflight, rs_cnt;
  logic [RSP_CW:0]   crd_used;
  logic              credit, issue, iss_last, ret;
  logic [TAG_W-1:0]  iss_tag;
  logic [PTR_W-1:0]  iss_ptr;
  logic [LEN_W-1:0]  iss_len, iss_idx;

  assign crd_used = {1'b0, inflight} + {1'b0, rs_cnt};
  assign credit   = (crd_used < (RSP_CW + 1)'(RSP_DEPTH));

  always_comb begin
    rq_pop  = 1'b0;
    issue   = 1'b0;
    iss_tag = cur_tag;
    iss_ptr = cur_ptr;
    iss_len = cur_len;
    iss_idx = idx;
    if (rst_n) begin
      if (state == S_IDLE) begin
        if (!rq_empty) begin
          rq_pop  = 1'b1;
          issue   = credit;
          iss_tag = rq_tag_mem[rq_rd];
          iss_ptr = rq_ptr_mem[rq_rd];
          iss_len = rq_len_mem[rq_rd];
          iss_idx = '0;
        end
      end else begin
        issue = credit;
      end
    end
  end

  assign iss_last    = (iss_idx == iss_len);
  assign mem_rd_en   = issue;
  assign mem_rd_addr = issue ? (iss_ptr + PTR_W'(iss_idx)) : '0;

  always_ff @(posedge clk) begin
    if (rq_pop) begin
      cur_tag <= iss_tag;
      cur_ptr <= iss_ptr;
      cur_len <= iss_len;
    end
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else if (issue) begin
      if (iss_last) begin
        state <= S_IDLE;
        idx   <= '0;
      end else begin
        state <= S_FETCH;
        idx   <= iss_idx + 1'b1;
      end
    end else if (rq_pop) begin
      state <= S_FETCH;
      idx   <= '0;
    end
  end

  // Sideband pipe p0..p(RD_LAT-1), aligned so the last stage meets mem_rd_data
  logic             sb_vld_p [RD_LAT];
  logic [TAG_W-1:0] sb_tag_p [RD_LAT];
  logic             sb_sop_p [RD_LAT];
  logic             sb_eop_p [RD_LAT];

  always_ff @(posedge clk) begin
    sb_tag_p[0] <= iss_tag;
    sb_sop_p[0] <= (iss_idx == '0);
    sb_eop_p[0] <= iss_last;
    for (int i = 1; i < RD_LAT; i++) begin
      sb_tag_p[i] <= sb_tag_p[i-1];
      sb_sop_p[i] <= sb_sop_p[i-1];
      sb_eop_p[i] <= sb_eop_p[i-1];
    end
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) sb_vld_p[i] <= 1'b0;
    end else begin
      sb_vld_p[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) sb_vld_p[i] <= sb_vld_p[i-1];
    end
  end

  assign ret = sb_vld_p[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n)            inflight <= '0;
    else if (issue & ~ret) inflight <= inflight + 1'b1;
    else if (ret & ~issue) inflight <= inflight - 1'b1;
  end

  // Response FIFO; credit accounting guarantees it never overflows
  logic [DATA_W-1:0] rs_data_mem [RSP_DEPTH];
  logic [TAG_W-1:0]  rs_tag_mem  [RSP_DEPTH];
  logic              rs_sop_mem  [RSP_DEPTH];
  logic              rs_eop_mem  [RSP_DEPTH];
  logic [RSP_AW-1:0] rs_wr, rs_rd;
  logic              rs_pop;

  assign rsp_valid = rst_n & (rs_cnt != '0);
  assign rs_pop    = rsp_valid & rsp_ready;
  assign rsp_data  = rsp_valid ? rs_data_mem[rs_rd] : '0;
  assign rsp_tag   = rsp_valid ? rs_tag_mem[rs_rd]  : '0;
  assign rsp_sop   = rsp_valid & rs_sop_mem[rs_rd];
  assign rsp_eop   = rsp_valid & rs_eop_mem[rs_rd];

  always_ff @(posedge clk) begin
    if (ret) begin
      rs_data_mem[rs_wr] <= mem_rd_data;
      rs_tag_mem[rs_wr]  <= sb_tag_p[RD_LAT-1];
      rs_sop_mem[rs_wr]  <= sb_sop_p[RD_LAT-1];
      rs_eop_mem[rs_wr]  <= sb_eop_p[RD_LAT-1];
    end
    if (!rst_n) begin
      rs_wr  <= '0;
      rs_rd  <= '0;
      rs_cnt <= '0;
    end else begin
      if (ret)    rs_wr <= rsp_inc(rs_wr);
      if (rs_pop) rs_rd <= rsp_inc(rs_rd);
      rs_cnt <= rs_cnt + RSP_CW'(ret) - RSP_CW'(rs_pop);
    end
  end

  assign idle = rst_n & rq_empty & (state == S_IDLE) & (inflight == '0) & (rs_cnt == '0);

`ifdef EGR_PRC_FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_req_cnt <= '0;
      perf_seg_cnt <= '0;
    end else begin
      if (rq_push) perf_req_cnt <= sat_inc(perf_req_cnt);
      if (rs_pop)  perf_seg_cnt <= sat_inc(perf_seg_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_egr_prc_fetch_rsp.sv
// Directed self-checking bench for egr_prc_fetch_rsp with a fixed-latency memory model.
module tb_egr_prc_fetch_rsp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [7:0]  req_tag;
  logic [15:0] req_ptr;
  logic [4:0]  req_nseg_m1;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_tag;
  logic        rsp_sop, rsp_eop;
  logic [63:0] rsp_data;
  logic        idle;
`ifdef EGR_PRC_FETCH_PERF_EN
  logic [31:0] perf_req_cnt, perf_seg_cnt;
`endif

  egr_prc_fetch_rsp dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_ptr(req_ptr), .req_nseg_m1(req_nseg_m1),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_sop(rsp_sop), .rsp_eop(rsp_eop), .rsp_data(rsp_data), .idle(idle)
`ifdef EGR_PRC_FETCH_PERF_EN
    , .perf_req_cnt(perf_req_cnt), .perf_seg_cnt(perf_seg_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [63:0] dfn(input logic [15:0] a);
    return {a, ~a, 16'h5A00 ^ a, 16'hC3C3};
  endfunction

  // Memory with a read latency of two cycles
  logic [1:0]  m_en = 2'b00;
  logic [15:0] m_a0 = '0, m_a1 = '0;
  always @(posedge clk) begin
    m_en <= {m_en[0], mem_rd_en};
    m_a0 <= mem_rd_addr;
    m_a1 <= m_a0;
  end
  assign mem_rd_data = m_en[1] ? dfn(m_a1) : 64'hBAD0_BAD0_BAD0_BAD0;

  typedef struct {
    logic [7:0]  tag;
    logic        sop;
    logic        eop;
    logic [63:0] data;
    int          cyc;
  } beat_t;

  logic [15:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  beat_t       bq[$];
  beat_t       mon_b;

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_addr_q.push_back(mem_rd_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (rsp_valid && rsp_ready) begin
      mon_b.tag  = rsp_tag;
      mon_b.sop  = rsp_sop;
      mon_b.eop  = rsp_eop;
      mon_b.data = rsp_data;
      mon_b.cyc  = cyc;
      bq.push_back(mon_b);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    bq.delete();
  endtask

  task automatic send_req(input logic [7:0] t, input logic [15:0] p, input logic [4:0] n,
                          output int acc);
    req_valid   = 1'b1;
    req_tag     = t;
    req_ptr     = p;
    req_nseg_m1 = n;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("req_accept_timeout", {63'b0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (idle) break;
    end
    chk("wait_idle", {63'b0, idle}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc6, rr;
    logic [15:0] t2_addr [4];
    t2_addr[0] = 16'hFFFE; t2_addr[1] = 16'hFFFF; t2_addr[2] = 16'h0000; t2_addr[3] = 16'h0001;

    rst_n = 1'b0; req_valid = 1'b0; req_tag = '0; req_ptr = '0; req_nseg_m1 = '0; rsp_ready = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_req_ready", {63'b0, req_ready}, 64'd0);
    chk("rst_idle", {63'b0, idle}, 64'd0);
    chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rst_mem_rd_en", {63'b0, mem_rd_en}, 64'd0);
    chk("rst_mem_rd_addr", {48'b0, mem_rd_addr}, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", {63'b0, req_ready}, 64'd1);
    chk("rel_idle", {63'b0, idle}, 64'd1);
    @(posedge clk); #1;

    // 1: three segments from 0x0010
    clear_q();
    send_req(8'h5A, 16'h0010, 5'd2, acc);
    wait_idle(100);
    chk("t1_nreads", rd_addr_q.size(), 3);
    chk("t1_nbeats", bq.size(), 3);
    if (rd_addr_q.size() == 3 && bq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_addr", {48'b0, rd_addr_q[i]}, 64'h10 + i);
        chk("t1_rd_cyc", rd_cyc_q[i], acc + 1 + i);
        chk("t1_tag", {56'b0, bq[i].tag}, 64'h5A);
        chk("t1_sop", {63'b0, bq[i].sop}, (i == 0) ? 64'd1 : 64'd0);
        chk("t1_eop", {63'b0, bq[i].eop}, (i == 2) ? 64'd1 : 64'd0);
        chk("t1_data", bq[i].data, dfn(16'h0010 + 16'(i)));
      end
      chk("t1_first_rsp_cyc", bq[0].cyc, acc + 4);
    end
`ifdef EGR_PRC_FETCH_PERF_EN
    chk("t1_perf_req", perf_req_cnt, 64'd1);
    chk("t1_perf_seg", perf_seg_cnt, 64'd3);
`endif

    // 2: pointer wrap
    clear_q();
    send_req(8'h22, 16'hFFFE, 5'd3, acc);
    wait_idle(100);
    chk("t2_nbeats", bq.size(), 4);
    if (rd_addr_q.size() == 4 && bq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_addr", {48'b0, rd_addr_q[i]}, {48'b0, t2_addr[i]});
        chk("t2_data", bq[i].data, dfn(t2_addr[i]));
      end
      chk("t2_eop", {63'b0, bq[3].eop}, 64'd1);
    end

    // 3: backpressure stops issue at eight reads
    clear_q();
    rsp_ready = 1'b0;
    send_req(8'h33, 16'h0100, 5'd31, acc);
    tick(20);
    @(negedge clk);
    chk("t3_reads_stalled", rd_addr_q.size(), 8);
    chk("t3_rd_en_low", {63'b0, mem_rd_en}, 64'd0);
    chk("t3_hold_valid", {63'b0, rsp_valid}, 64'd1);
    chk("t3_hold_data", rsp_data, dfn(16'h0100));
    tick(3);
    @(negedge clk);
    chk("t3_hold_data2", rsp_data, dfn(16'h0100));
    chk("t3_hold_sop", {63'b0, rsp_sop}, 64'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle(200);
    chk("t3_nreads", rd_addr_q.size(), 32);
    chk("t3_nbeats", bq.size(), 32);
    if (bq.size() == 32) begin
      for (int i = 0; i < 32; i++) chk("t3_data", bq[i].data, dfn(16'h0100 + 16'(i)));
      chk("t3_eop", {63'b0, bq[31].eop}, 64'd1);
    end

    // 4: request queue fills under backpressure
    clear_q();
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_req(8'h41 + 8'(k), 16'h1000 * 16'(k + 1), 5'd31, acc);
    req_valid = 1'b1; req_tag = 8'h46; req_ptr = 16'h6000; req_nseg_m1 = 5'd31;
    rr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) rr++;
    end
    chk("t4_sixth_blocked", rr, 0);
    chk("t4_reads_stalled", rd_addr_q.size(), 8);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    acc6 = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc6 = cyc;
        break;
      end
    end
    chk("t4_sixth_accepted", {63'b0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t4_pop_after_last", {63'b0, (rd_cyc_q.size() >= 32) && (acc6 > rd_cyc_q[31])}, 64'd1);
    wait_idle(1000);
    chk("t4_nbeats", bq.size(), 192);
    if (bq.size() == 192) begin
      for (int k = 0; k < 6; k++) begin
        chk("t4_tag", {56'b0, bq[32*k].tag}, 64'h41 + k);
        chk("t4_sop", {63'b0, bq[32*k].sop}, 64'd1);
        chk("t4_eop", {63'b0, bq[32*k+31].eop}, 64'd1);
        chk("t4_data", bq[32*k+5].data, dfn(16'h1000 * 16'(k + 1) + 16'd5));
      end
    end

    // 5: back-to-back single-segment requests
    clear_q();
    send_req(8'h01, 16'h0020, 5'd0, acc);
    send_req(8'h02, 16'h0030, 5'd0, acc);
    wait_idle(100);
    chk("t5_nbeats", bq.size(), 2);
    if (rd_cyc_q.size() == 2 && bq.size() == 2) begin
      chk("t5_consecutive", rd_cyc_q[1], rd_cyc_q[0] + 1);
      chk("t5_addr1", {48'b0, rd_addr_q[1]}, 64'h30);
      chk("t5_beat0", {54'b0, bq[0].tag, bq[0].sop, bq[0].eop}, {54'b0, 8'h01, 2'b11});
      chk("t5_beat1", {54'b0, bq[1].tag, bq[1].sop, bq[1].eop}, {54'b0, 8'h02, 2'b11});
    end

    // 6: reset mid-fetch
    send_req(8'h77, 16'h0200, 5'd31, acc);
    tick(4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_rd_en", {63'b0, mem_rd_en}, 64'd0);
    chk("t6_rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("t6_rst_req_ready", {63'b0, req_ready}, 64'd0);
    chk("t6_rst_idle", {63'b0, idle}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_q();
    @(negedge clk);
    chk("t6_idle_after", {63'b0, idle}, 64'd1);
`ifdef EGR_PRC_FETCH_PERF_EN
    chk("t6_perf_req", perf_req_cnt, 64'd0);
    chk("t6_perf_seg", perf_seg_cnt, 64'd0);
`endif
    tick(10);
    chk("t6_no_stale_beats", bq.size(), 0);
    chk("t6_no_reads", rd_addr_q.size(), 0);
    chk("t6_still_idle", {63'b0, idle}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
